// File: rtl/instr_encoder_if.sv
// Handshake bundle between a field-bundle producer, the instruction encoder,
// and the downstream word consumer.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [9:0]  func;
  logic [11:0] imms;
  logic [19:0] imml;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [7:0]  err_cnt;

  modport slave (
    input  in_valid, fmt, opcode, rs1, rs2, rd, func, imms, imml, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err_cnt
  );

  modport master (
    output in_valid, fmt, opcode, rs1, rs2, rd, func, imms, imml, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err_cnt
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field-bundle to instruction-word packer with an output FIFO and a
// running byte address for the word at the FIFO head.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  instr_encoder_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   enc;
  logic          legal;
  logic [6:0]    f7;
  logic [2:0]    f3;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [31:0]   addr;
  logic [7:0]    err;
  logic          acc, push, pop;

  assign f7 = bus.func[9:3];
  assign f3 = bus.func[2:0];

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (bus.fmt)
      3'd0: enc = {f7, bus.rs2, bus.rs1, f3, bus.rd, bus.opcode};
      3'd1: enc = {bus.imms, bus.rs1, f3, bus.rd, bus.opcode};
      3'd2: enc = {bus.imms[11:5], bus.rs2, bus.rs1, f3, bus.imms[4:0], bus.opcode};
      3'd3: enc = {bus.imms[11], bus.imms[9:4], bus.rs2, bus.rs1, f3,
                   bus.imms[3:0], bus.imms[10], bus.opcode};
      3'd4: enc = {bus.imml, bus.rd, bus.opcode};
      3'd5: enc = {bus.imml[19], bus.imml[9:0], bus.imml[10], bus.imml[18:11],
                   bus.rd, bus.opcode};
      default: legal = 1'b0;
    endcase
  end

  // No bypass: a full FIFO refuses input even when the head is popping.
  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = mem[rptr];
  assign bus.out_addr  = addr;
  assign bus.err_cnt   = err;

  assign acc  = bus.in_valid & bus.in_ready & ~rst;
  assign push = acc & legal;
  assign pop  = bus.out_valid & bus.out_ready & ~rst;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= enc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      addr  <= BASE_ADDR;
      err   <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr <= rptr + AW'(1);
        addr <= addr + 32'd4;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Illegal formats are swallowed and only counted.
      if (acc && !legal && err != 8'hFF) err <= err + 8'd1;
    end
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Buffered RV32I instruction encoder, the inverse of the instruction decoder. It accepts decoded field bundles (register indices, `{funct7,funct3}` function code, short/long immediates, format and opcode) over a valid/ready handshake and packs each bundle into a 32-bit instruction word. Each word goes into a small FIFO and is presented downstream with a running byte address. It sits between test/program generators and instruction-memory loaders, so decoder round-trip checks can run end to end.

## Interface
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `BASE_ADDR`, 32'h0000_0000, address of first emitted word
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  field bundle present
- `in_ready`  out  1  bundle accepted when `in_valid & in_ready`
- `fmt`  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- `opcode`  in  7  instr[6:0]
- `rs1`, `rs2`, `rd`  in  5 each  register indices
- `func`  in  10  `{funct7, funct3}`
- `imms`  in  12  I/S: imm[11:0]; B: offset[12:1]
- `imml`  in  20  U: imm[31:12]; J: offset[20:1]
- `out_valid`  out  1  word available
- `out_ready`  in  1  word consumed when `out_valid & out_ready`
- `out_instr`  out  32  encoded word at FIFO head
- `out_addr`  out  32  address of `out_instr`
- `err_cnt`  out  8  count of dropped illegal-format bundles, saturating at 255

## Operation
- Encoding (f7=func[9:3], f3=func[2:0]):
  - R: `{f7, rs2, rs1, f3, rd, opcode}`
  - I: `{imms, rs1, f3, rd, opcode}`
  - S: `{imms[11:5], rs2, rs1, f3, imms[4:0], opcode}`
  - B: `{imms[11], imms[9:4], rs2, rs1, f3, imms[3:0], imms[10], opcode}`
  - U: `{imml, rd, opcode}`
  - J: `{imml[19], imml[9:0], imml[10], imml[18:11], rd, opcode}`
- Fields not used by a format are ignored. No range or opcode/format consistency checks.
- Illegal `fmt` (6,7): the bundle is accepted if `in_ready`, is not written to the FIFO, and increments `err_cnt` (saturating).
- FIFO: circular buffer of `DEPTH` entries, with read/write pointers plus an occupancy counter (0..DEPTH). `in_ready = (count != DEPTH)`. `out_valid = (count != 0)`.
- Pushing on a legal accepted bundle and popping on an output handshake in the same cycle leaves `count` unchanged. Pointers wrap modulo `DEPTH`.
- No bypass: at full, `in_ready` is low even if a pop occurs in the same cycle.
- Address counter: starts at `BASE_ADDR` and increments by 4 on each output handshake. `out_addr` is combinational from the counter and always tracks the head word. It wraps modulo 2^32.

## Timing
- Reset (`rst` high at a rising edge) sets `count=0`, both pointers to 0, the address counter to `BASE_ADDR`, and `err_cnt=0`. Consequently `in_ready=1`, `out_valid=0`, `out_addr=BASE_ADDR`. `out_instr` is don't-care while `out_valid=0`.
- Reset mid-operation discards all buffered words. No handshake completes in a reset cycle.
- Latency: a bundle accepted at edge N shows at `out_instr` with `out_valid=1` after edge N, when the FIFO was empty. Encoding is combinational before the FIFO write.
- Throughput: 1 word/cycle when `out_ready` is held high.
- `out_instr`/`out_addr` stay stable while `out_valid & !out_ready`.
- An illegal bundle updates `err_cnt` after its acceptance edge and does not change `count` or the address counter.

## Test plan
- Reset, then I: opcode 0x13, f3=0, rd=1, rs1=0, imms=5 -> `out_instr=0x00500093`, `out_addr=0x0`, one cycle after accept.
- Back-to-back stream R ADD(op 0x33, func 0, rd3, rs1 1, rs2 2), S SW(op 0x23, f3 2, rs1 1, rs2 2, imms 8), B BEQ(op 0x63, rs1 1, rs2 2, imms 4), U LUI(op 0x37, rd5, imml 0x12345), J JAL(op 0x6F, rd1, imml 4) with `out_ready=1` -> 0x002081B3, 0x0020A423, 0x00208463, 0x123452B7, 0x008000EF at addresses 0x0,0x4,0x8,0xC,0x10.
- `out_ready=0`, push 5 legal bundles -> `in_ready` drops after the 4th accept, and the 5th waits. Raise `out_ready` for one cycle -> one pop, then the 5th is accepted the next cycle. Order is preserved.
- Simultaneous push/pop at count=2 for 10 cycles -> count stays 2, addresses advance by 4 per cycle, and pointer wrap is exercised.
- fmt=6 and fmt=7 bundles interleaved with legal bundles -> `err_cnt=2`, no FIFO entries for the illegal bundles, and the address sequence stays contiguous. Then 300 illegal bundles -> `err_cnt=255`.
- Assert `rst` with 3 words buffered -> next cycle `out_valid=0`, `in_ready=1`, `out_addr=BASE_ADDR`, `err_cnt=0`.
